// File: rtl/bp_fe_pkg.sv
// Shared front-end types for the BHT update path.
// The idx field width is fixed here; keep the queue's bht_idx_width_p at the default.
package bp_fe_pkg;

  localparam int bht_idx_width_gp = 9;

  typedef struct packed {
    logic [bht_idx_width_gp-1:0] idx;
    logic                        taken;
  } bp_fe_bht_upd_entry_s;

  typedef struct packed {
    logic                        w_v;
    logic [bht_idx_width_gp-1:0] idx;
    logic                        correct;
    logic                        pred_taken;
  } bp_fe_bht_upd_s;

endpackage

// File: rtl/bp_fe_bht_upd_fifo.sv
// Circular buffer holding in-flight predictions.
// It supports simultaneous enqueue and dequeue and a flush that squashes everything left.
module bp_fe_bht_upd_fifo #(
  parameter int els_p   = 8,
  parameter int width_p = 10
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enq_v_i,
  input  logic [width_p-1:0] enq_data_i,
  input  logic               deq_v_i,
  input  logic               flush_i,
  output logic [width_p-1:0] head_o,
  output logic               ready_o,
  output logic               empty_o
);

  localparam int ptr_w = $clog2(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rptr, wptr, rptr_n, wptr_n;
  logic [ptr_w:0]     count, count_n;
  logic               ready;
  logic               enq_fire, deq_fire;

  // A flush squashes any same-cycle enqueue. The dequeue still pops, so its result stays valid.
  assign enq_fire = enq_v_i & ready & ~flush_i;
  assign deq_fire = deq_v_i & (count != '0);

  // Next pointers and count. A flush snaps the read pointer onto the write pointer.
  always_comb begin
    wptr_n  = wptr + ptr_w'(enq_fire);
    rptr_n  = rptr + ptr_w'(deq_fire);
    count_n = count + (ptr_w+1)'(enq_fire) - (ptr_w+1)'(deq_fire);
    if (flush_i) begin
      rptr_n  = wptr;
      count_n = '0;
    end
  end

  // Pointer, count and registered ready state.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      ready <= 1'b1;
    end else begin
      rptr  <= rptr_n;
      wptr  <= wptr_n;
      count <= count_n;
      ready <= (count_n != (ptr_w+1)'(els_p));
    end
  end

  // Entry storage. Contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq_fire) mem[wptr] <= enq_data_i;
  end

  assign head_o  = mem[rptr];
  assign ready_o = ready;
  assign empty_o = (count == '0);

endmodule

// File: rtl/bp_fe_bht_update_queue.sv
// Tracks in-flight branch predictions and converts in-order resolutions into
// registered BHT write-port updates. It also keeps saturating resolve and mispredict counters.
module bp_fe_bht_update_queue
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = bht_idx_width_gp,
  parameter int els_p           = 8,
  parameter int perf_width_p    = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       enq_v_i,
  output logic                       enq_ready_o,
  input  logic [bht_idx_width_p-1:0] enq_idx_i,
  input  logic                       enq_taken_i,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       bht_w_v_o,
  output logic [bht_idx_width_p-1:0] bht_idx_w_o,
  output logic                       bht_correct_o,
  output logic                       bht_pred_taken_o,
  output logic                       empty_o,
  output logic                       err_underflow_o,
  output logic [perf_width_p-1:0]    perf_res_o,
  output logic [perf_width_p-1:0]    perf_mispred_o
);

  bp_fe_bht_upd_entry_s   enq_entry, head;
  bp_fe_bht_upd_s         upd;
  logic                   empty, res_fire, mispred;
  logic                   err;
  logic [perf_width_p-1:0] perf_res, perf_mispred;

  assign enq_entry = '{idx: enq_idx_i, taken: enq_taken_i};

  bp_fe_bht_upd_fifo #(
    .els_p   (els_p),
    .width_p ($bits(bp_fe_bht_upd_entry_s))
  ) fifo (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .enq_v_i    (enq_v_i),
    .enq_data_i (enq_entry),
    .deq_v_i    (res_v_i),
    .flush_i    (flush_i),
    .head_o     (head),
    .ready_o    (enq_ready_o),
    .empty_o    (empty)
  );

  // A resolve against an empty queue never pops and never writes the BHT.
  assign res_fire = res_v_i & ~empty;
  assign mispred  = (head.taken != res_taken_i);

  // Result register. The valid bit pulses for one cycle and the payload holds until the next resolve.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      upd <= '0;
    end else begin
      upd.w_v <= res_fire;
      if (res_fire) begin
        upd.idx        <= head.idx;
        upd.correct    <= ~mispred;
        upd.pred_taken <= head.taken;
      end
    end
  end

  // Sticky underflow flag. Only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)                err <= 1'b0;
    else if (res_v_i && empty)     err <= 1'b1;
  end

  // Perf counters stop at all-ones instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      perf_res     <= '0;
      perf_mispred <= '0;
    end else if (res_fire) begin
      if (perf_res != '1)                perf_res     <= perf_res + 1'b1;
      if (mispred && perf_mispred != '1) perf_mispred <= perf_mispred + 1'b1;
    end
  end

  assign bht_w_v_o        = upd.w_v;
  assign bht_idx_w_o      = upd.idx;
  assign bht_correct_o    = upd.correct;
  assign bht_pred_taken_o = upd.pred_taken;
  assign empty_o          = empty;
  assign err_underflow_o  = err;
  assign perf_res_o       = perf_res;
  assign perf_mispred_o   = perf_mispred;

endmodule

// File: tb/tb_bp_fe_bht_update_queue.sv
// Scoreboard bench for bp_fe_bht_update_queue. Expected BHT writes are queued when a
// resolve is issued, and a monitor pops and compares them whenever bht_w_v_o is seen.
module tb_bp_fe_bht_update_queue;

  localparam int W  = 9;
  localparam int D  = 8;
  localparam int PW = 4;  // narrow perf counters so saturation is reachable
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          enq_v_i, enq_taken_i, res_v_i, res_taken_i, flush_i;
  logic [W-1:0]  enq_idx_i;
  logic          enq_ready_o, bht_w_v_o, bht_correct_o, bht_pred_taken_o, empty_o, err_underflow_o;
  logic [W-1:0]  bht_idx_w_o;
  logic [PW-1:0] perf_res_o, perf_mispred_o;

  always #5 clk = ~clk;

  bp_fe_bht_update_queue #(.bht_idx_width_p(W), .els_p(D), .perf_width_p(PW)) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .enq_v_i(enq_v_i), .enq_ready_o(enq_ready_o), .enq_idx_i(enq_idx_i), .enq_taken_i(enq_taken_i),
    .res_v_i(res_v_i), .res_taken_i(res_taken_i), .flush_i(flush_i),
    .bht_w_v_o(bht_w_v_o), .bht_idx_w_o(bht_idx_w_o), .bht_correct_o(bht_correct_o),
    .bht_pred_taken_o(bht_pred_taken_o), .empty_o(empty_o), .err_underflow_o(err_underflow_o),
    .perf_res_o(perf_res_o), .perf_mispred_o(perf_mispred_o)
  );

  typedef struct { logic [W-1:0] idx; logic correct; logic pred; } exp_t;
  typedef struct { logic [W-1:0] idx; logic taken; } ent_t;

  exp_t sbq[$];
  ent_t mq[$];
  int   n_chk = 0, n_fail = 0;
  int   m_res = 0, m_mis = 0;
  logic m_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bht_w_v_o !== 1'b0) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got w_v=%b idx=%0h expected no write at %0t",
                   bht_w_v_o, bht_idx_w_o, $time);
        end else begin
          e = sbq.pop_front();
          chk("wr_idx", bht_idx_w_o, e.idx);
          chk("wr_correct", bht_correct_o, e.correct);
          chk("wr_pred", bht_pred_taken_o, e.pred);
        end
      end
    end
  endtask

  task automatic clr_in();
    enq_v_i = 0; enq_idx_i = '0; enq_taken_i = 0; res_v_i = 0; res_taken_i = 0; flush_i = 0;
  endtask

  // Called at a negedge: drives one cycle, updates the model, then checks state at the next negedge
  task automatic cyc(input logic e, input logic [W-1:0] ix, input logic et,
                     input logic r, input logic rt, input logic f);
    int   sz;
    ent_t h;
    sz = mq.size();
    enq_v_i = e; enq_idx_i = ix; enq_taken_i = et; res_v_i = r; res_taken_i = rt; flush_i = f;
    if (r && sz > 0) begin
      h = mq.pop_front();
      sbq.push_back('{idx: h.idx, correct: (h.taken == rt), pred: h.taken});
      if (m_res < PMAX) m_res++;
      if (h.taken != rt && m_mis < PMAX) m_mis++;
    end
    if (r && sz == 0) m_err = 1'b1;
    if (f) mq.delete();
    else if (e && sz < D) mq.push_back('{idx: ix, taken: et});
    @(posedge clk); #1;
    clr_in();
    @(negedge clk);
    chk("empty", empty_o, mq.size() == 0);
    chk("enq_ready", enq_ready_o, mq.size() < D);
    chk("err_underflow", err_underflow_o, m_err);
    chk("perf_res", perf_res_o, m_res);
    chk("perf_mispred", perf_mispred_o, m_mis);
  endtask

  // Reset for one edge, optionally with a resolve on the same edge; its write must be suppressed
  task automatic do_reset(input logic with_res);
    reset_n_i = 0; res_v_i = with_res; res_taken_i = 1;
    @(posedge clk); #1;
    reset_n_i = 1; clr_in();
    mq.delete(); sbq.delete(); m_res = 0; m_mis = 0; m_err = 0;
    @(negedge clk);
    chk("rst_empty", empty_o, 1);
    chk("rst_ready", enq_ready_o, 1);
    chk("rst_w_v", bht_w_v_o, 0);
    chk("rst_err", err_underflow_o, 0);
    chk("rst_perf_res", perf_res_o, 0);
    chk("rst_perf_mis", perf_mispred_o, 0);
  endtask

  initial begin
    fork monitor(); join_none
    clr_in();
    reset_n_i = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);
    chk("rst_idx", bht_idx_w_o, 0);
    chk("rst_correct", bht_correct_o, 0);

    // 1: single mispredict
    cyc(1, 9'h0A1, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t1_w_v", bht_w_v_o, 1);
    chk("t1_idx", bht_idx_w_o, 9'h0A1);
    chk("t1_correct", bht_correct_o, 0);
    chk("t1_pred", bht_pred_taken_o, 1);
    chk("t1_mispred", perf_mispred_o, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_pulse", bht_w_v_o, 0);
    chk("t1_hold_idx", bht_idx_w_o, 9'h0A1);

    // 2: fill to full, drop a 9th, then drain in order
    for (int i = 0; i < 9; i++) cyc(1, W'(9'h100 + i), i[0], 0, 0, 0);
    chk("t2_full_ready", enq_ready_o, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, i[1], 0);

    // 3: steady state at count 3 with pointer wrap; the counters saturate here
    for (int i = 0; i < 3; i++) cyc(1, W'(9'h020 + i), 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(1, W'(9'h040 + i), i[0], 1, i[2], 0);
    chk("t3_sat_res", perf_res_o, PMAX);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);

    // 4: flush with count 5; the head resolve still writes and the same-cycle enq is dropped
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cyc(1, W'(9'h1E0 + i), i[0], 0, 0, 0);
    cyc(1, 9'h1FF, 1, 1, 1, 1);
    chk("t4_w_v", bht_w_v_o, 1);
    chk("t4_idx", bht_idx_w_o, 9'h1E0);
    chk("t4_correct", bht_correct_o, 0);
    chk("t4_empty", empty_o, 1);
    cyc(1, 9'h0F0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);

    // 5: underflow, sticky error, and same-cycle enq+res while empty
    cyc(0, 0, 0, 1, 1, 0);
    chk("t5_no_write", bht_w_v_o, 0);
    chk("t5_err", err_underflow_o, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("t5_err_sticky", err_underflow_o, 1);
    cyc(1, 9'h055, 0, 1, 1, 0);
    chk("t5_enq_landed", empty_o, 0);
    cyc(0, 0, 0, 1, 1, 0);

    // 6: reset mid-stream with a resolve on the reset edge, then resume
    for (int i = 0; i < 4; i++) cyc(1, W'(9'h0C0 + i), 1, 0, 0, 0);
    do_reset(1'b1);
    cyc(1, 9'h133, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    chk("t6_idx", bht_idx_w_o, 9'h133);
    chk("t6_correct", bht_correct_o, 1);
    cyc(0, 0, 0, 0, 0, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
